// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair: FSM state
// encoding and the frame-position counter width.
package serdes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Width of a counter that indexes n words (n is at least 2, so >= 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned N_SAMPLES_DEF = 8;
  localparam int unsigned CNT_W_DEF     = cnt_width(N_SAMPLES_DEF);

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with enable and synchronous active-low reset. The wrap at
// MODULUS-1 is an explicit compare, so non-power-of-2 moduli never run past
// their last legal value.
module wrap_counter
  import serdes_pkg::*;
#(
  parameter int unsigned MODULUS = 8,
  parameter int unsigned W       = cnt_width(MODULUS)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o
);

  localparam logic [W-1:0] MAX = W'(MODULUS - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign at_max_o = (count_q == MAX);
  assign count_o  = count_q;

  // Next count: advance on enable, return to zero after the last value.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = at_max_o ? '0 : count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serializer.sv
// Frame serializer: captures N_SAMPLES words in one recv transfer and plays
// them out one word per send transfer, word 0 first. recv_rdy and send_val
// are decoded purely from state, so capture and send never overlap.
module serializer
  import serdes_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0],
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  output logic                 send_val,
  input  logic                 send_rdy
);

  localparam int unsigned CNT_W = cnt_width(N_SAMPLES);

  state_e               state_q;
  state_e               state_d;
  logic [BIT_WIDTH-1:0] frame_q [N_SAMPLES-1:0];
  logic [CNT_W-1:0]     count;
  logic                 at_max;
  logic                 recv_fire;
  logic                 send_fire;

  assign recv_fire = recv_val && recv_rdy;
  assign send_fire = send_val && send_rdy;

  // Word position within the frame; it sits at zero whenever the block is
  // idle, so a fresh capture always starts from word 0.
  wrap_counter #(
    .MODULUS (N_SAMPLES),
    .W       (CNT_W)
  ) u_count (
    .clk_i    (clk),
    .rst_ni   (reset),
    .en_i     (send_fire),
    .count_o  (count),
    .at_max_o (at_max)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame register: loaded only on the capture edge, so later recv_msg
  // activity cannot disturb the frame being sent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_SAMPLES); i++) begin
        frame_q[i] <= '0;
      end
    end else if (recv_fire) begin
      frame_q <= recv_msg;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = '0;
    unique case (state_q)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          state_d = SEND;
        end
      end
      SEND: begin
        send_val = 1'b1;
        send_msg = frame_q[count];
        if (send_rdy && at_max) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
